axi_stream_burst_writer: RTL and testbench



---
 rtl/axi_stream_burst_writer_pkg.sv | 31 +++
 rtl/axi_stream_burst_writer_if.sv | 67 ++++++
 rtl/axi_stream_burst_writer_splitter.sv | 69 ++++++
 rtl/axi_stream_burst_writer.sv | 209 ++++++++++++++++++++
 tb/tb_axi_stream_burst_writer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stream_burst_writer_pkg.sv
// ----------------------------------------------------------------------------
// axi_writer_pkg
// Shared types and constants for the AXI stream burst writer.
//   state_t    : writer FSM state encoding (also exported on dbg_state)
//   BURST_INCR : AXI INCR burst encoding driven on awburst
//   RESP_OKAY  : AXI OKAY response encoding
//   clog2()    : elaboration-time log2 used to derive awsize
// ----------------------------------------------------------------------------
package axi_writer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // Smallest n with 2**n >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axi_stream_burst_writer_if.sv
// ----------------------------------------------------------------------------
// axi_stream_burst_writer_if
// Bundles the input data stream and the AXI4 write channels (AW, W, B).
//   Stream : s_data, s_valid (into writer), s_ready (out of writer)
//   AW     : axi_awid/awaddr/awlen/awsize/awburst/awvalid, axi_awready
//   W      : axi_wdata/wstrb/wlast/wvalid, axi_wready
//   B      : axi_bresp/bvalid, axi_bready
// Modports:
//   master : the writer side (drives AW/W/bready and s_ready)
//   slave  : the memory/stream-source side
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; a valid, once raised, is held with a
// stable payload until that edge.
// ----------------------------------------------------------------------------
interface axi_stream_burst_writer_if #(
   parameter int ASIZE  = 32,
   parameter int DSIZE  = 64,
   parameter int IDSIZE = 4,
   parameter int LSIZE  = 8
);
   import axi_writer_pkg::*;

   logic [DSIZE-1:0]   s_data;
   logic               s_valid;
   logic               s_ready;

   logic [IDSIZE-1:0]  axi_awid;
   logic [ASIZE-1:0]   axi_awaddr;
   logic [LSIZE-1:0]   axi_awlen;
   logic [2:0]         axi_awsize;
   logic [1:0]         axi_awburst;
   logic               axi_awvalid;
   logic               axi_awready;

   logic [DSIZE-1:0]   axi_wdata;
   logic [DSIZE/8-1:0] axi_wstrb;
   logic               axi_wlast;
   logic               axi_wvalid;
   logic               axi_wready;

   logic [1:0]         axi_bresp;
   logic               axi_bvalid;
   logic               axi_bready;

   modport master (
      input  s_data, s_valid,
      output s_ready,
      output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
      input  axi_awready,
      output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      input  axi_wready,
      input  axi_bresp, axi_bvalid,
      output axi_bready
   );

   modport slave (
      output s_data, s_valid,
      input  s_ready,
      input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
      output axi_awready,
      input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      output axi_wready,
      output axi_bresp, axi_bvalid,
      input  axi_bready
   );

endinterface

// File: rtl/axi_stream_burst_writer_splitter.sv
// ----------------------------------------------------------------------------
// axi_burst_splitter
// Holds the current burst address and the number of beats still to write,
// and derives the length of the next burst from them.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture load_addr / load_beats (transfer start)
//   advance         : current burst fully written; step address, drop beats
//   addr            : address of the next burst's first beat
//   remaining       : beats not yet covered by a completed burst
//   burst_len_m1    : min(BURST_LEN, remaining) - 1, forced to 0 when
//                     nothing remains so awlen idles at zero
// Addresses wrap modulo 2**ASIZE.
// ----------------------------------------------------------------------------
module axi_burst_splitter
   import axi_writer_pkg::*;
#(
   parameter int ASIZE     = 32,
   parameter int LSIZE     = 8,
   parameter int BURST_LEN = 16,
   parameter int ADDR_STEP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [ASIZE-1:0] load_addr,
   input  logic [31:0]      load_beats,
   input  logic             advance,
   output logic [ASIZE-1:0] addr,
   output logic [31:0]      remaining,
   output logic [LSIZE-1:0] burst_len_m1
);

   logic [ASIZE-1:0] addr_q, addr_d;
   logic [31:0]      remaining_q, remaining_d;
   logic [31:0]      burst;
   logic [ASIZE-1:0] addr_inc;

   always_comb begin
      burst = (remaining_q < 32'(BURST_LEN)) ? remaining_q : 32'(BURST_LEN);
      burst_len_m1 = (burst == 32'd0) ? '0 : LSIZE'(burst - 32'd1);
      addr_inc = ASIZE'(burst * 32'(ADDR_STEP));
   end

   always_comb begin
      addr_d      = addr_q;
      remaining_d = remaining_q;
      if (load) begin
         addr_d      = load_addr;
         remaining_d = load_beats;
      end else if (advance) begin
         addr_d      = addr_q + addr_inc;
         remaining_d = remaining_q - burst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
      end
   end

   assign addr      = addr_q;
   assign remaining = remaining_q;

endmodule

// File: rtl/axi_stream_burst_writer.sv
// ----------------------------------------------------------------------------
// axi_stream_burst_writer
// AXI4 write master that drains a valid/ready stream into memory as INCR
// bursts of up to BURST_LEN beats, starting at a programmed address and
// stepping ADDR_STEP per beat. One burst is outstanding at a time and its AW
// is always issued before its W beats.
// Ports:
//   axi_aclk, axi_rst : clock, synchronous active-high reset
//   cfg_start         : one-cycle start request (ignored while busy)
//   cfg_addr          : first beat address
//   cfg_beats         : total beats (0 gives a lone done pulse)
//   busy              : transfer in progress
//   done              : one-cycle pulse at transfer end
//   err_cnt           : count of non-OKAY write responses
//   dbg_state         : current FSM state
//   bus               : stream + AW/W/B channels (master modport)
// Build option:
//   AXI_WRITER_BRESP_CHECK_EN : when defined, every accepted non-OKAY bresp
//   bumps err_cnt (saturating, cleared only by reset); otherwise bresp is
//   ignored and err_cnt is held at zero.
// ----------------------------------------------------------------------------
module axi_stream_burst_writer
   import axi_writer_pkg::*;
#(
   parameter int ASIZE     = 32,
   parameter int DSIZE     = 64,
   parameter int IDSIZE    = 4,
   parameter int LSIZE     = 8,
   parameter int ID        = 0,
   parameter int BURST_LEN = 16,
   parameter int ADDR_STEP = 1
) (
   input  logic                      axi_aclk,
   input  logic                      axi_rst,
   input  logic                      cfg_start,
   input  logic [ASIZE-1:0]          cfg_addr,
   input  logic [31:0]               cfg_beats,
   output logic                      busy,
   output logic                      done,
   output logic [15:0]               err_cnt,
   output state_t                    dbg_state,
   axi_stream_burst_writer_if.master bus
);

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [LSIZE-1:0] beat_cnt_q, beat_cnt_d;

   logic             load;
   logic             advance;
   logic [ASIZE-1:0] cur_addr;
   logic [31:0]      remaining;
   logic [LSIZE-1:0] burst_len_m1;

   logic             aw_valid;
   logic             w_valid;
   logic             w_last;
   logic             s_ready;
   logic             b_ready;

   axi_burst_splitter #(
      .ASIZE     (ASIZE),
      .LSIZE     (LSIZE),
      .BURST_LEN (BURST_LEN),
      .ADDR_STEP (ADDR_STEP)
   ) u_splitter (
      .clk          (axi_aclk),
      .rst          (axi_rst),
      .load         (load),
      .load_addr    (cfg_addr),
      .load_beats   (cfg_beats),
      .advance      (advance),
      .addr         (cur_addr),
      .remaining    (remaining),
      .burst_len_m1 (burst_len_m1)
   );

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      beat_cnt_d = beat_cnt_q;
      load       = 1'b0;
      advance    = 1'b0;
      aw_valid   = 1'b0;
      w_valid    = 1'b0;
      w_last     = 1'b0;
      s_ready    = 1'b0;
      b_ready    = 1'b0;

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               if (cfg_beats != 32'd0) begin
                  load    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ADDR;
               end else begin
                  // Empty transfer: acknowledge without touching the bus.
                  done_d = 1'b1;
               end
            end
         end

         ADDR: begin
            // Payload comes straight from the splitter registers, which only
            // change on load/advance, so it is stable while awvalid waits.
            aw_valid = 1'b1;
            if (bus.axi_awready) begin
               beat_cnt_d = '0;
               state_d    = DATA;
            end
         end

         DATA: begin
            // Zero-latency pass-through between stream and W channel.
            w_valid = bus.s_valid;
            s_ready = bus.axi_wready;
            w_last  = (beat_cnt_q == burst_len_m1);
            if (bus.s_valid && bus.axi_wready) begin
               if (w_last) begin
                  advance    = 1'b1;
                  beat_cnt_d = '0;
                  state_d    = RESP;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end

         RESP: begin
            b_ready = 1'b1;
            if (bus.axi_bvalid) begin
               // remaining was already reduced by the advance in DATA.
               if (remaining == 32'd0) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = ADDR;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef AXI_WRITER_BRESP_CHECK_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (bus.axi_bvalid && b_ready && (bus.axi_bresp != RESP_OKAY) &&
          (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic bresp_unused;
   assign bresp_unused = ^bus.axi_bresp;
   assign err_cnt      = '0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

   assign bus.s_ready     = s_ready;
   assign bus.axi_awid    = IDSIZE'(ID);
   assign bus.axi_awaddr  = cur_addr;
   assign bus.axi_awlen   = burst_len_m1;
   assign bus.axi_awsize  = 3'(clog2(DSIZE / 8));
   assign bus.axi_awburst = BURST_INCR;
   assign bus.axi_awvalid = aw_valid;
   assign bus.axi_wdata   = bus.s_data;
   assign bus.axi_wstrb   = '1;
   assign bus.axi_wlast   = w_last;
   assign bus.axi_wvalid  = w_valid;
   assign bus.axi_bready  = b_ready;

endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// ----------------------------------------------------------------------------
// tb_axi_stream_burst_writer
// Directed bench for axi_stream_burst_writer with a memory-side responder
// and stream source that can insert random stalls, plus a capture of every
// AW and W transfer for comparison against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_axi_stream_burst_writer;
   import axi_writer_pkg::*;

   localparam int ASIZE  = 32;
   localparam int DSIZE  = 64;
   localparam int IDSIZE = 4;
   localparam int LSIZE  = 8;

`ifdef AXI_WRITER_BRESP_CHECK_EN
   localparam logic [15:0] EXP_ERR = 16'd1;
`else
   localparam logic [15:0] EXP_ERR = 16'd0;
`endif

   logic              axi_aclk = 1'b0;
   logic              axi_rst;
   logic              cfg_start;
   logic [ASIZE-1:0]  cfg_addr;
   logic [31:0]       cfg_beats;
   logic              busy;
   logic              done;
   logic [15:0]       err_cnt;
   state_t            dbg_state;

   axi_stream_burst_writer_if #(
      .ASIZE(ASIZE), .DSIZE(DSIZE), .IDSIZE(IDSIZE), .LSIZE(LSIZE)
   ) bus ();

   axi_stream_burst_writer #(
      .ASIZE(ASIZE), .DSIZE(DSIZE), .IDSIZE(IDSIZE), .LSIZE(LSIZE),
      .ID(0), .BURST_LEN(16), .ADDR_STEP(1)
   ) dut (
      .axi_aclk  (axi_aclk),
      .axi_rst   (axi_rst),
      .cfg_start (cfg_start),
      .cfg_addr  (cfg_addr),
      .cfg_beats (cfg_beats),
      .busy      (busy),
      .done      (done),
      .err_cnt   (err_cnt),
      .dbg_state (dbg_state),
      .bus       (bus)
   );

   // ---------------- clock ----------------
   always #5 axi_aclk = ~axi_aclk;

   // ---------------- bench state ----------------
   int               total = 0;
   int               bad   = 0;
   bit               stall_en = 1'b0;
   int               err_burst = -1;
   logic [DSIZE-1:0] src_q[$];
   int               src_idx = 0;
   logic [ASIZE-1:0] aw_addr_q[$];
   logic [LSIZE-1:0] aw_len_q[$];
   logic [DSIZE-1:0] w_data_q[$];
   logic             w_last_q[$];
   int               pend_b = 0;
   int               b_idx = 0;
   int               done_cnt = 0;
   int               aw_unstable = 0;
   int               awvalid_cycles = 0;
   bit               busy_seen = 1'b0;
   bit               aw_hold = 1'b0;
   logic [ASIZE-1:0] hold_addr;
   logic [LSIZE-1:0] hold_len;
   bit               s_taken = 1'b0;
   bit               b_taken = 1'b0;

   // ---------------- memory responder / stream source / capture ----------------
   // Inputs change on the falling edge; transfers are recorded 1ns later,
   // which is what the next rising edge will see.
   initial begin : bfm
      forever begin
         @(negedge axi_aclk);
         if (axi_rst) begin
            bus.s_valid     = 1'b0;
            bus.axi_awready = 1'b0;
            bus.axi_wready  = 1'b0;
            bus.axi_bvalid  = 1'b0;
            bus.axi_bresp   = 2'b00;
            pend_b  = 0;
            aw_hold = 1'b0;
            s_taken = 1'b0;
            b_taken = 1'b0;
         end else begin
            if (s_taken) bus.s_valid = 1'b0;
            if (!bus.s_valid && (src_idx < src_q.size())) begin
               bus.s_valid = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
               bus.s_data  = src_q[src_idx];
            end
            bus.axi_awready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
            bus.axi_wready  = stall_en ? ($urandom_range(0, 1) == 0) : 1'b1;
            if (b_taken) bus.axi_bvalid = 1'b0;
            if (!bus.axi_bvalid && (pend_b > 0)) begin
               bus.axi_bvalid = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
               bus.axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
            end
            #1;
            if (bus.axi_awvalid) begin
               awvalid_cycles++;
               if (aw_hold && ((bus.axi_awaddr !== hold_addr) || (bus.axi_awlen !== hold_len)))
                  aw_unstable++;
               if (bus.axi_awready) begin
                  aw_addr_q.push_back(bus.axi_awaddr);
                  aw_len_q.push_back(bus.axi_awlen);
                  aw_hold = 1'b0;
               end else begin
                  aw_hold   = 1'b1;
                  hold_addr = bus.axi_awaddr;
                  hold_len  = bus.axi_awlen;
               end
            end
            if (bus.axi_wvalid && bus.axi_wready) begin
               w_data_q.push_back(bus.axi_wdata);
               w_last_q.push_back(bus.axi_wlast);
               if (bus.axi_wlast) pend_b++;
            end
            s_taken = bus.s_valid && bus.s_ready;
            if (s_taken) src_idx++;
            b_taken = bus.axi_bvalid && bus.axi_bready;
            if (b_taken) begin
               pend_b--;
               b_idx++;
            end
            if (done) done_cnt++;
            if (busy) busy_seen = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_capture();
      aw_addr_q.delete();
      aw_len_q.delete();
      w_data_q.delete();
      w_last_q.delete();
      b_idx = 0;
      done_cnt = 0;
      aw_unstable = 0;
      awvalid_cycles = 0;
      busy_seen = 1'b0;
   endtask

   task automatic load_source(input int n, input logic [DSIZE-1:0] seed);
      src_q.delete();
      src_idx = 0;
      for (int i = 0; i < n; i++) src_q.push_back(seed + 64'(i) * 64'h0001_0000_0000_0101);
   endtask

   task automatic start_xfer(input logic [ASIZE-1:0] addr, input logic [31:0] beats);
      @(negedge axi_aclk);
      cfg_addr  = addr;
      cfg_beats = beats;
      cfg_start = 1'b1;
      @(negedge axi_aclk);
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge axi_aclk);
         #2;
         if (done_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge axi_aclk);
      #2;
      total++; if (bus.axi_awvalid !== 1'b0) begin bad++; $display("FAIL reset_awvalid: got %b want 0", bus.axi_awvalid); end
      total++; if (bus.axi_wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid: got %b want 0", bus.axi_wvalid); end
      total++; if (bus.axi_bready !== 1'b0) begin bad++; $display("FAIL reset_bready: got %b want 0", bus.axi_bready); end
      total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (bus.axi_awaddr !== 32'h0) begin bad++; $display("FAIL reset_awaddr: got %h want 0", bus.axi_awaddr); end
      total++; if (bus.axi_awlen !== 8'h0) begin bad++; $display("FAIL reset_awlen: got %h want 0", bus.axi_awlen); end
      total++; if (err_cnt !== 16'h0) begin bad++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt); end
      total++; if (bus.axi_awid !== 4'h0) begin bad++; $display("FAIL const_awid: got %h want 0", bus.axi_awid); end
      total++; if (bus.axi_awsize !== 3'd3) begin bad++; $display("FAIL const_awsize: got %0d want 3", bus.axi_awsize); end
      total++; if (bus.axi_awburst !== 2'b01) begin bad++; $display("FAIL const_awburst: got %b want 01", bus.axi_awburst); end
      total++; if (bus.axi_wstrb !== 8'hFF) begin bad++; $display("FAIL const_wstrb: got %h want ff", bus.axi_wstrb); end
   endtask

   task automatic test_basic();
      logic [ASIZE-1:0] ea[3];
      logic [LSIZE-1:0] el[3];
      logic [DSIZE-1:0] exp_q[$];
      bit ok;
      ea = '{32'h100, 32'h110, 32'h120};
      el = '{8'd15, 8'd15, 8'd7};
      clear_capture();
      stall_en = 1'b0;
      load_source(40, 64'hA5A5_0000_0000_0000);
      for (int i = 0; i < 40; i++) exp_q.push_back(64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0001_0000_0000_0101);
      start_xfer(32'h100, 32'd40);
      wait_done(1, 600, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_done: no done within budget"); end
      total++; if (aw_addr_q.size() !== 3) begin bad++; $display("FAIL basic_aw_count: got %0d want 3", aw_addr_q.size()); end
      for (int k = 0; k < 3 && k < aw_addr_q.size(); k++) begin
         total++; if (aw_addr_q[k] !== ea[k]) begin bad++; $display("FAIL basic_awaddr[%0d]: got %h want %h", k, aw_addr_q[k], ea[k]); end
         total++; if (aw_len_q[k] !== el[k]) begin bad++; $display("FAIL basic_awlen[%0d]: got %0d want %0d", k, aw_len_q[k], el[k]); end
      end
      total++; if (w_data_q.size() !== 40) begin bad++; $display("FAIL basic_beats: got %0d want 40", w_data_q.size()); end
      for (int i = 0; i < 40 && i < w_data_q.size(); i++) begin
         total++; if (w_data_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_wdata[%0d]: got %h want %h", i, w_data_q[i], exp_q[i]); end
         total++; if (w_last_q[i] !== ((i == 15) || (i == 31) || (i == 39))) begin bad++; $display("FAIL basic_wlast[%0d]: got %b", i, w_last_q[i]); end
      end
      repeat (3) @(negedge axi_aclk);
      #2;
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_single();
      bit ok;
      clear_capture();
      stall_en = 1'b0;
      load_source(1, 64'h1234_5678_9ABC_DEF0);
      start_xfer(32'h40, 32'd1);
      wait_done(1, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_done: no done within budget"); end
      total++; if (aw_addr_q.size() !== 1) begin bad++; $display("FAIL single_aw_count: got %0d want 1", aw_addr_q.size()); end
      if (aw_addr_q.size() > 0) begin
         total++; if (aw_addr_q[0] !== 32'h40) begin bad++; $display("FAIL single_awaddr: got %h want 40", aw_addr_q[0]); end
         total++; if (aw_len_q[0] !== 8'd0) begin bad++; $display("FAIL single_awlen: got %0d want 0", aw_len_q[0]); end
      end
      total++; if (w_data_q.size() !== 1) begin bad++; $display("FAIL single_beats: got %0d want 1", w_data_q.size()); end
      if (w_data_q.size() > 0) begin
         total++; if (w_data_q[0] !== 64'h1234_5678_9ABC_DEF0) begin bad++; $display("FAIL single_wdata: got %h", w_data_q[0]); end
         total++; if (w_last_q[0] !== 1'b1) begin bad++; $display("FAIL single_wlast: got %b want 1", w_last_q[0]); end
      end
   endtask

   task automatic test_zero();
      clear_capture();
      src_q.delete();
      src_idx = 0;
      @(negedge axi_aclk);
      cfg_addr  = 32'h300;
      cfg_beats = 32'd0;
      cfg_start = 1'b1;
      @(negedge axi_aclk);
      cfg_start = 1'b0;
      #2;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done_pulse: got %b want 1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
      @(negedge axi_aclk);
      #2;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %b want 0", done); end
      repeat (5) @(negedge axi_aclk);
      #2;
      total++; if (awvalid_cycles !== 0) begin bad++; $display("FAIL zero_awvalid: got %0d cycles want 0", awvalid_cycles); end
      total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL zero_busy_seen: got %b want 0", busy_seen); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_stalls();
      logic [ASIZE-1:0] ea[3];
      logic [LSIZE-1:0] el[3];
      logic [DSIZE-1:0] exp_q[$];
      logic [ASIZE-1:0] last_addr;
      bit ok;
      ea = '{32'h100, 32'h110, 32'h120};
      el = '{8'd15, 8'd15, 8'd7};
      clear_capture();
      stall_en = 1'b1;
      load_source(40, 64'h5A00_0000_0000_0000);
      for (int i = 0; i < 40; i++) exp_q.push_back(64'h5A00_0000_0000_0000 + 64'(i) * 64'h0001_0000_0000_0101);
      start_xfer(32'h100, 32'd40);
      wait_done(1, 3000, ok);
      stall_en = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL stall_done: no done within budget"); end
      total++; if (aw_addr_q.size() !== 3) begin bad++; $display("FAIL stall_aw_count: got %0d want 3", aw_addr_q.size()); end
      for (int k = 0; k < 3 && k < aw_addr_q.size(); k++) begin
         total++; if (aw_addr_q[k] !== ea[k]) begin bad++; $display("FAIL stall_awaddr[%0d]: got %h want %h", k, aw_addr_q[k], ea[k]); end
         total++; if (aw_len_q[k] !== el[k]) begin bad++; $display("FAIL stall_awlen[%0d]: got %0d want %0d", k, aw_len_q[k], el[k]); end
      end
      if (aw_addr_q.size() == 3) begin
         last_addr = aw_addr_q[2] + 32'(aw_len_q[2]);
         total++; if (last_addr !== 32'h127) begin bad++; $display("FAIL stall_last_addr: got %h want 127", last_addr); end
      end
      total++; if (w_data_q.size() !== 40) begin bad++; $display("FAIL stall_beats: got %0d want 40", w_data_q.size()); end
      for (int i = 0; i < 40 && i < w_data_q.size(); i++) begin
         total++; if (w_data_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_wdata[%0d]: got %h want %h", i, w_data_q[i], exp_q[i]); end
         total++; if (w_last_q[i] !== ((i == 15) || (i == 31) || (i == 39))) begin bad++; $display("FAIL stall_wlast[%0d]: got %b", i, w_last_q[i]); end
      end
      total++; if (aw_unstable !== 0) begin bad++; $display("FAIL stall_aw_stable: got %0d changes want 0", aw_unstable); end
   endtask

   task automatic test_start_ignored_and_reset();
      bit ok;
      clear_capture();
      stall_en = 1'b1;
      load_source(40, 64'hC000_0000_0000_0000);
      start_xfer(32'h100, 32'd40);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge axi_aclk);
         #2;
         if (w_data_q.size() >= 5) begin ok = 1'b1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL midrst_progress: got %0d beats want >=5", w_data_q.size()); end
      start_xfer(32'h900, 32'd3);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge axi_aclk);
         #2;
         if (dbg_state == DATA) begin ok = 1'b1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL midrst_reach_data: state %0d never DATA", dbg_state); end
      axi_rst = 1'b1;
      @(negedge axi_aclk);
      @(negedge axi_aclk);
      #2;
      total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL midrst_state: got %0d want IDLE", dbg_state); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      total++; if (bus.axi_awvalid !== 1'b0) begin bad++; $display("FAIL midrst_awvalid: got %b want 0", bus.axi_awvalid); end
      total++; if (bus.axi_wvalid !== 1'b0) begin bad++; $display("FAIL midrst_wvalid: got %b want 0", bus.axi_wvalid); end
      total++; if (bus.axi_awaddr !== 32'h0) begin bad++; $display("FAIL midrst_awaddr: got %h want 0", bus.axi_awaddr); end
      total++; if (bus.axi_awlen !== 8'h0) begin bad++; $display("FAIL midrst_awlen: got %h want 0", bus.axi_awlen); end
      total++; if (bus.axi_bready !== 1'b0) begin bad++; $display("FAIL midrst_bready: got %b want 0", bus.axi_bready); end
      total++; if (done_cnt !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); end
      for (int k = 0; k < aw_addr_q.size(); k++) begin
         total++; if (aw_addr_q[k] === 32'h900) begin bad++; $display("FAIL midrst_start_ignored: aw[%0d]=%h want not 900", k, aw_addr_q[k]); end
      end
      @(negedge axi_aclk);
      axi_rst  = 1'b0;
      stall_en = 1'b0;
      clear_capture();
      load_source(20, 64'hE000_0000_0000_0000);
      start_xfer(32'h200, 32'd20);
      wait_done(1, 300, ok);
      total++; if (!ok) begin bad++; $display("FAIL fresh_done: no done within budget"); end
      total++; if (aw_addr_q.size() !== 2) begin bad++; $display("FAIL fresh_aw_count: got %0d want 2", aw_addr_q.size()); end
      if (aw_addr_q.size() == 2) begin
         total++; if (aw_addr_q[0] !== 32'h200) begin bad++; $display("FAIL fresh_awaddr0: got %h want 200", aw_addr_q[0]); end
         total++; if (aw_addr_q[1] !== 32'h210) begin bad++; $display("FAIL fresh_awaddr1: got %h want 210", aw_addr_q[1]); end
         total++; if (aw_len_q[0] !== 8'd15) begin bad++; $display("FAIL fresh_awlen0: got %0d want 15", aw_len_q[0]); end
         total++; if (aw_len_q[1] !== 8'd3) begin bad++; $display("FAIL fresh_awlen1: got %0d want 3", aw_len_q[1]); end
      end
      total++; if (w_data_q.size() !== 20) begin bad++; $display("FAIL fresh_beats: got %0d want 20", w_data_q.size()); end
      if (w_data_q.size() == 20) begin
         total++; if (w_data_q[19] !== 64'hE000_0000_0000_0000 + 64'd19 * 64'h0001_0000_0000_0101) begin bad++; $display("FAIL fresh_last_data: got %h", w_data_q[19]); end
      end
   endtask

   task automatic test_bresp();
      bit ok;
      clear_capture();
      stall_en  = 1'b0;
      err_burst = 1;
      load_source(40, 64'h0B00_0000_0000_0000);
      start_xfer(32'h100, 32'd40);
      wait_done(1, 600, ok);
      err_burst = -1;
      total++; if (!ok) begin bad++; $display("FAIL bresp_done: no done within budget"); end
      total++; if (aw_addr_q.size() !== 3) begin bad++; $display("FAIL bresp_aw_count: got %0d want 3", aw_addr_q.size()); end
      total++; if (w_data_q.size() !== 40) begin bad++; $display("FAIL bresp_beats: got %0d want 40", w_data_q.size()); end
      total++; if (err_cnt !== EXP_ERR) begin bad++; $display("FAIL bresp_err_cnt: got %0d want %0d", err_cnt, EXP_ERR); end
   endtask

   // ---------------- watchdog ----------------
   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   // ---------------- sequence + report ----------------
   initial begin : main
      axi_rst         = 1'b1;
      cfg_start       = 1'b0;
      cfg_addr        = '0;
      cfg_beats       = '0;
      bus.s_valid     = 1'b0;
      bus.s_data      = '0;
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b0;
      bus.axi_bvalid  = 1'b0;
      bus.axi_bresp   = 2'b00;
      repeat (3) @(negedge axi_aclk);
      test_reset();
      @(negedge axi_aclk);
      axi_rst = 1'b0;
      test_basic();
      test_single();
      test_zero();
      test_stalls();
      test_start_ignored_and_reset();
      test_bresp();
      repeat (3) @(negedge axi_aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
